// File: rtl/fifo_downsize_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_downsize_rd_ctrl
//
// Read-side sequencer for a downsizing FIFO. Each wide FIFO entry is unpacked
// into RATIO narrow lanes. The block drives the FIFO's lane mux, pop strobe and
// output-register hold. It presents the FIFO's registered narrow output as a
// valid/ready stream. A command gives the starting lane and the beat count, so
// unaligned starts and partial final entries follow AXI narrow-burst rules.
//
// Ports
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   cmd_valid/ready : command handshake (ready only while idle)
//   cmd_lane        : lane of the first beat within the first wide entry
//   cmd_len         : narrow beat count minus one
//   fifo_empty      : FIFO empty flag
//   fifo_rd_en      : pop the current wide entry at this edge
//   fifo_rd_src     : lane select into the FIFO output mux
//   fifo_data_hold  : freeze the FIFO output register
//   out_valid/ready : narrow beat stream handshake (data is FIFO data_out)
//   out_last        : current beat is the final beat of its command
//   busy            : command in progress or beat still pending
// -----------------------------------------------------------------------------
module fifo_downsize_rd_ctrl #(
    parameter int DATA_WIDTH_IN  = 64,
    parameter int DATA_WIDTH_OUT = 32,
    parameter int LEN_WIDTH      = 8,
    localparam int RATIO         = DATA_WIDTH_IN / DATA_WIDTH_OUT,
    localparam int LANE_W        = $clog2(RATIO)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [LANE_W-1:0]    cmd_lane,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    output logic [LANE_W-1:0]    fifo_rd_src,
    output logic                 fifo_data_hold,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 issue_s;
    logic                 final_lane_s;
    logic                 final_beat_s;

    // An issue loads a new beat into the FIFO output register. It is allowed
    // when the register is free or its current beat is being accepted now.
    assign issue_s      = (state_q == RUN) && !fifo_empty && (!valid_q || out_ready);
    assign final_lane_s = (lane_q == LANE_W'(RATIO - 1));
    assign final_beat_s = (rem_q == {LEN_WIDTH{1'b0}});

    // Next-state, counters and FIFO read controls.
    always_comb begin
        state_d        = state_q;
        lane_d         = lane_q;
        rem_d          = rem_q;
        valid_d        = valid_q;
        last_d         = last_q;
        fifo_rd_en     = 1'b0;
        fifo_rd_src    = lane_q;
        fifo_data_hold = valid_q && !out_ready;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = RUN;
                    lane_d  = cmd_lane;
                    rem_d   = cmd_len;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (issue_s) begin
                    // Pop on the edge that captures the entry's last used lane,
                    // so a partial final entry is still consumed.
                    fifo_rd_en = final_lane_s || final_beat_s;
                    lane_d     = lane_q + LANE_W'(1);
                    rem_d      = rem_q - LEN_WIDTH'(1);
                    if (final_beat_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue_s) begin
            fifo_data_hold = 1'b0;
            valid_d        = 1'b1;
            last_d         = final_beat_s;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            valid_d = valid_q;
            last_d  = last_q;
        end
    end

    // State and datapath-control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lane_q  <= {LANE_W{1'b0}};
            rem_q   <= {LEN_WIDTH{1'b0}};
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign busy      = (state_q == RUN) || valid_q;

endmodule

// File: tb/tb_fifo_downsize_rd_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for fifo_downsize_rd_ctrl: a RATIO=2 instance (a_*) and a RATIO=4
// instance (b_*) driven from one table of per-cycle vectors. A small
// behavioural FIFO output register tracks the selected instance so the narrow
// data order can be checked as well as the control outputs.
// -----------------------------------------------------------------------------
module tb_fifo_downsize_rd_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // RATIO=2 instance
    logic       a_cmd_valid, a_cmd_ready, a_cmd_lane;
    logic [7:0] a_cmd_len;
    logic       a_fifo_empty, a_rd_en, a_rd_src, a_hold;
    logic       a_out_valid, a_out_ready, a_out_last, a_busy;

    // RATIO=4 instance
    logic       b_cmd_valid, b_cmd_ready;
    logic [1:0] b_cmd_lane;
    logic [7:0] b_cmd_len;
    logic       b_fifo_empty, b_rd_en;
    logic [1:0] b_rd_src;
    logic       b_hold, b_out_valid, b_out_ready, b_out_last, b_busy;

    fifo_downsize_rd_ctrl #(.DATA_WIDTH_IN(64), .DATA_WIDTH_OUT(32), .LEN_WIDTH(8)) u_dut_a (
        .clk(clk), .rst(rst),
        .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
        .cmd_lane(a_cmd_lane), .cmd_len(a_cmd_len),
        .fifo_empty(a_fifo_empty), .fifo_rd_en(a_rd_en),
        .fifo_rd_src(a_rd_src), .fifo_data_hold(a_hold),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_last(a_out_last), .busy(a_busy)
    );

    fifo_downsize_rd_ctrl #(.DATA_WIDTH_IN(128), .DATA_WIDTH_OUT(32), .LEN_WIDTH(8)) u_dut_b (
        .clk(clk), .rst(rst),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_lane(b_cmd_lane), .cmd_len(b_cmd_len),
        .fifo_empty(b_fifo_empty), .fifo_rd_en(b_rd_en),
        .fifo_rd_src(b_rd_src), .fifo_data_hold(b_hold),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_last(b_out_last), .busy(b_busy)
    );

    // Behavioural FIFO read side: entry k, lane j holds 32'h1000*(k+1)+j.
    logic        sel_b = 1'b0;
    int          rp;
    logic [31:0] dout;
    logic        m_rd_en, m_hold;
    logic [1:0]  m_src;

    function automatic logic [31:0] beat(input int k, input logic [1:0] j);
        return 32'h0000_1000 * (k + 1) + {30'd0, j};
    endfunction

    assign m_rd_en = sel_b ? b_rd_en : a_rd_en;
    assign m_hold  = sel_b ? b_hold : a_hold;
    assign m_src   = sel_b ? b_rd_src : {1'b0, a_rd_src};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rp   <= 0;
            dout <= 32'd0;
        end else begin
            if (!m_hold) dout <= beat(rp, m_src);
            if (m_rd_en) rp <= rp + 1;
        end
    end

    typedef struct {
        logic        dut_b;
        logic        rst;
        logic        cv;
        logic [1:0]  lane;
        logic [7:0]  len;
        logic        empty;
        logic        ordy;
        logic        e_cready;
        logic        e_rden;
        logic [1:0]  e_src;
        logic        e_hold;
        logic        e_ov;
        logic        e_last;
        logic        e_busy;
        logic [31:0] e_data;
    } vec_t;

    vec_t vq[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic add(input logic dut_b, input logic r, input logic cv, input logic [1:0] lane,
                       input logic [7:0] len, input logic empty, input logic ordy,
                       input logic cr, input logic en, input logic [1:0] src, input logic hold,
                       input logic ov, input logic last, input logic busy, input logic [31:0] data);
        vec_t v;
        v.dut_b = dut_b; v.rst = r; v.cv = cv; v.lane = lane; v.len = len;
        v.empty = empty; v.ordy = ordy; v.e_cready = cr; v.e_rden = en; v.e_src = src;
        v.e_hold = hold; v.e_ov = ov; v.e_last = last; v.e_busy = busy; v.e_data = data;
        vq.push_back(v);
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL timeout: bench did not finish within the wait limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        logic [7:0] got, want;
        a_cmd_valid = 1'b0; a_cmd_lane = 1'b0; a_cmd_len = 8'd0; a_fifo_empty = 1'b1; a_out_ready = 1'b1;
        b_cmd_valid = 1'b0; b_cmd_lane = 2'd0; b_cmd_len = 8'd0; b_fifo_empty = 1'b1; b_out_ready = 1'b1;

        @(negedge clk);
        if (a_cmd_ready !== 1'b1 || a_rd_en !== 1'b0 || a_rd_src !== 1'b0 || a_hold !== 1'b0 ||
            a_out_valid !== 1'b0 || a_out_last !== 1'b0 || a_busy !== 1'b0 ||
            b_cmd_ready !== 1'b1 || b_rd_en !== 1'b0 || b_rd_src !== 2'd0 || b_hold !== 1'b0 ||
            b_out_valid !== 1'b0 || b_out_last !== 1'b0 || b_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset state: a={%b,%b,%b,%b,%b,%b,%b} b={%b,%b,%b,%b,%b,%b,%b}",
                     a_cmd_ready, a_rd_en, a_rd_src, a_hold, a_out_valid, a_out_last, a_busy,
                     b_cmd_ready, b_rd_en, b_rd_src, b_hold, b_out_valid, b_out_last, b_busy);
        end

        //   B  rst cv lane len   emp rdy | cr en src hold ov last busy data
        // Aligned 4-beat burst, RATIO=2
        add(0, 1, 0, 0, 8'd0, 1, 1,   1, 0, 0, 0, 0, 0, 0, 32'h0);
        add(0, 0, 1, 0, 8'd3, 0, 1,   1, 0, 0, 0, 0, 0, 0, 32'h0);
        add(0, 0, 0, 0, 8'd0, 0, 1,   0, 0, 0, 0, 0, 0, 1, 32'h0);
        add(0, 0, 0, 0, 8'd0, 0, 1,   0, 1, 1, 0, 1, 0, 1, 32'h1000);
        add(0, 0, 0, 0, 8'd0, 0, 1,   0, 0, 0, 0, 1, 0, 1, 32'h1001);
        add(0, 0, 0, 0, 8'd0, 0, 1,   0, 1, 1, 0, 1, 0, 1, 32'h2000);
        add(0, 0, 0, 0, 8'd0, 1, 1,   1, 0, 0, 0, 1, 1, 1, 32'h2001);
        add(0, 0, 0, 0, 8'd0, 1, 1,   1, 0, 0, 0, 0, 0, 0, 32'h0);
        // Unaligned single beat, RATIO=2, lane 1
        add(0, 1, 0, 0, 8'd0, 1, 1,   1, 0, 0, 0, 0, 0, 0, 32'h0);
        add(0, 0, 1, 1, 8'd0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 32'h0);
        add(0, 0, 0, 0, 8'd0, 0, 1,   0, 1, 1, 0, 0, 0, 1, 32'h0);
        add(0, 0, 0, 0, 8'd0, 1, 1,   1, 0, 0, 0, 1, 1, 1, 32'h1001);
        add(0, 0, 0, 0, 8'd0, 1, 1,   1, 0, 0, 0, 0, 0, 0, 32'h0);
        // Partial entry, RATIO=4, lane 2, len 2 -> lanes 2,3,0
        add(1, 1, 0, 0, 8'd0, 1, 1,   1, 0, 0, 0, 0, 0, 0, 32'h0);
        add(1, 0, 1, 2, 8'd2, 0, 1,   1, 0, 0, 0, 0, 0, 0, 32'h0);
        add(1, 0, 0, 0, 8'd0, 0, 1,   0, 0, 2, 0, 0, 0, 1, 32'h0);
        add(1, 0, 0, 0, 8'd0, 0, 1,   0, 1, 3, 0, 1, 0, 1, 32'h1002);
        add(1, 0, 0, 0, 8'd0, 0, 1,   0, 1, 0, 0, 1, 0, 1, 32'h1003);
        add(1, 0, 0, 0, 8'd0, 1, 1,   1, 0, 1, 0, 1, 1, 1, 32'h2000);
        add(1, 0, 0, 0, 8'd0, 1, 1,   1, 0, 1, 0, 0, 0, 0, 32'h0);
        // Backpressure on the second beat for 3 cycles, RATIO=2
        add(0, 1, 0, 0, 8'd0, 1, 1,   1, 0, 0, 0, 0, 0, 0, 32'h0);
        add(0, 0, 1, 0, 8'd3, 0, 1,   1, 0, 0, 0, 0, 0, 0, 32'h0);
        add(0, 0, 0, 0, 8'd0, 0, 1,   0, 0, 0, 0, 0, 0, 1, 32'h0);
        add(0, 0, 0, 0, 8'd0, 0, 1,   0, 1, 1, 0, 1, 0, 1, 32'h1000);
        add(0, 0, 0, 0, 8'd0, 0, 0,   0, 0, 0, 1, 1, 0, 1, 32'h1001);
        add(0, 0, 0, 0, 8'd0, 0, 0,   0, 0, 0, 1, 1, 0, 1, 32'h1001);
        add(0, 0, 0, 0, 8'd0, 0, 0,   0, 0, 0, 1, 1, 0, 1, 32'h1001);
        add(0, 0, 0, 0, 8'd0, 0, 1,   0, 0, 0, 0, 1, 0, 1, 32'h1001);
        add(0, 0, 0, 0, 8'd0, 0, 1,   0, 1, 1, 0, 1, 0, 1, 32'h2000);
        add(0, 0, 0, 0, 8'd0, 1, 1,   1, 0, 0, 0, 1, 1, 1, 32'h2001);
        add(0, 0, 0, 0, 8'd0, 1, 1,   1, 0, 0, 0, 0, 0, 0, 32'h0);
        // Empty stall after the first entry, RATIO=2
        add(0, 1, 0, 0, 8'd0, 1, 1,   1, 0, 0, 0, 0, 0, 0, 32'h0);
        add(0, 0, 1, 0, 8'd3, 0, 1,   1, 0, 0, 0, 0, 0, 0, 32'h0);
        add(0, 0, 0, 0, 8'd0, 0, 1,   0, 0, 0, 0, 0, 0, 1, 32'h0);
        add(0, 0, 0, 0, 8'd0, 0, 1,   0, 1, 1, 0, 1, 0, 1, 32'h1000);
        add(0, 0, 0, 0, 8'd0, 1, 1,   0, 0, 0, 0, 1, 0, 1, 32'h1001);
        add(0, 0, 0, 0, 8'd0, 1, 1,   0, 0, 0, 0, 0, 0, 1, 32'h0);
        add(0, 0, 0, 0, 8'd0, 0, 1,   0, 0, 0, 0, 0, 0, 1, 32'h0);
        add(0, 0, 0, 0, 8'd0, 0, 1,   0, 1, 1, 0, 1, 0, 1, 32'h2000);
        add(0, 0, 0, 0, 8'd0, 1, 1,   1, 0, 0, 0, 1, 1, 1, 32'h2001);
        add(0, 0, 0, 0, 8'd0, 1, 1,   1, 0, 0, 0, 0, 0, 0, 32'h0);
        // Reset after 2 of 4 beats, then a clean single-beat command
        add(0, 1, 0, 0, 8'd0, 1, 1,   1, 0, 0, 0, 0, 0, 0, 32'h0);
        add(0, 0, 1, 0, 8'd3, 0, 1,   1, 0, 0, 0, 0, 0, 0, 32'h0);
        add(0, 0, 0, 0, 8'd0, 0, 1,   0, 0, 0, 0, 0, 0, 1, 32'h0);
        add(0, 0, 0, 0, 8'd0, 0, 1,   0, 1, 1, 0, 1, 0, 1, 32'h1000);
        add(0, 0, 0, 0, 8'd0, 0, 1,   0, 0, 0, 0, 1, 0, 1, 32'h1001);
        add(0, 1, 0, 0, 8'd0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 32'h0);
        add(0, 0, 1, 0, 8'd0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 32'h0);
        add(0, 0, 0, 0, 8'd0, 0, 1,   0, 1, 0, 0, 0, 0, 1, 32'h0);
        add(0, 0, 0, 0, 8'd0, 1, 1,   1, 0, 1, 0, 1, 1, 1, 32'h1000);
        add(0, 0, 0, 0, 8'd0, 1, 1,   1, 0, 1, 0, 0, 0, 0, 32'h0);
        // Back-to-back commands, RATIO=4: lane 3 len 0, then lane 1 len 1
        add(1, 1, 0, 0, 8'd0, 1, 1,   1, 0, 0, 0, 0, 0, 0, 32'h0);
        add(1, 0, 1, 3, 8'd0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 32'h0);
        add(1, 0, 1, 1, 8'd1, 0, 1,   0, 1, 3, 0, 0, 0, 1, 32'h0);
        add(1, 0, 1, 1, 8'd1, 0, 1,   1, 0, 0, 0, 1, 1, 1, 32'h1003);
        add(1, 0, 0, 0, 8'd0, 0, 1,   0, 0, 1, 0, 0, 0, 1, 32'h0);
        add(1, 0, 0, 0, 8'd0, 0, 1,   0, 1, 2, 0, 1, 0, 1, 32'h2001);
        add(1, 0, 0, 0, 8'd0, 1, 1,   1, 0, 3, 0, 1, 1, 1, 32'h2002);
        add(1, 0, 0, 0, 8'd0, 1, 1,   1, 0, 3, 0, 0, 0, 0, 32'h0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst   = vq[i].rst;
            sel_b = vq[i].dut_b;
            if (vq[i].dut_b) begin
                b_cmd_valid = vq[i].cv; b_cmd_lane = vq[i].lane; b_cmd_len = vq[i].len;
                b_fifo_empty = vq[i].empty; b_out_ready = vq[i].ordy;
                a_cmd_valid = 1'b0; a_fifo_empty = 1'b1; a_out_ready = 1'b1;
            end else begin
                a_cmd_valid = vq[i].cv; a_cmd_lane = vq[i].lane[0]; a_cmd_len = vq[i].len;
                a_fifo_empty = vq[i].empty; a_out_ready = vq[i].ordy;
                b_cmd_valid = 1'b0; b_fifo_empty = 1'b1; b_out_ready = 1'b1;
            end
            #1;
            if (vq[i].dut_b)
                got = {b_cmd_ready, b_rd_en, b_rd_src, b_hold, b_out_valid, b_out_last, b_busy};
            else
                got = {a_cmd_ready, a_rd_en, 1'b0, a_rd_src, a_hold, a_out_valid, a_out_last, a_busy};
            want = {vq[i].e_cready, vq[i].e_rden, vq[i].e_src, vq[i].e_hold,
                    vq[i].e_ov, vq[i].e_last, vq[i].e_busy};
            n_vec++;
            if (got !== want || (vq[i].e_ov && dout !== vq[i].e_data)) begin
                n_fail++;
                $display("FAIL vec%0d: got {cr,en,src,hold,ov,last,busy}=%b data=%h, want %b data=%h",
                         i, got, dout, want, vq[i].e_ov ? vq[i].e_data : dout);
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
